// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the elastic pipeline stage register:
//   default widths, control-bit positions inside the CTRL word and
//   the occupancy encoding of the stage.
//   CTRL word layout (MSB..LSB):
//     {Branch, MemRead, MemToReg, MemWrite, RegWrite, jal, jalr, ALUSrc}
package pipe_pkg;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 142;
  localparam int DEF_CNT_W  = 16;

  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_JALR     = 1;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_BRANCH   = 7;

  // Number of beats currently held by the stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot
//   One storage entry of the stage: valid flag, control word and payload.
//   Control is zeroed whenever the slot is cleared so an empty slot can
//   never present live control bits; the payload only changes on load,
//   so it keeps the last beat after a clear.
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, zeroes everything
//   clear_i  in   drop the held beat (wins over load_i)
//   load_i   in   capture ctrl_i/data_i and mark valid
//   ctrl_i   in   control word to capture
//   data_i   in   payload to capture
//   valid_o  out  slot holds a beat
//   ctrl_o   out  held control word (0 when empty)
//   data_o   out  held payload
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic pipeline register between two RISC-V pipeline stages.
//   valid/ready handshake on both sides, optional second (skid) entry
//   so in_ready can be registered, synchronous flush, bubble control
//   zeroing and a saturating stall counter.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   OCC_EMPTY | nothing held, out_valid=0
//   OCC_ONE   | one beat in the main slot, presented on out_*
//   OCC_TWO   | main slot presented, skid slot holds the next beat;
//             | stage refuses new beats (SKID=1 only)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   flush      in   drop every held beat and the beat offered this cycle
//   in_valid   in   upstream beat present
//   in_ready   out  stage accepts a beat this cycle
//   in_ctrl    in   control word of incoming beat
//   in_data    in   payload of incoming beat
//   out_valid  out  beat presented downstream
//   out_ready  in   downstream accepts the beat this cycle
//   out_ctrl   out  control word, 0 on a bubble
//   out_data   out  payload, holds last value on a bubble
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_e              state_q, state_d;
  logic              in_xfer, out_xfer;
  logic              main_load, main_sel_skid, main_clear;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      state_d    = OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            state_d   = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with a skid entry; without one in_ready is
            // low whenever a held beat is not leaving.
            if (SKID) begin
              state_d   = OCC_TWO;
              skid_load = 1'b1;
            end
          end else if (out_xfer) begin
            state_d    = OCC_EMPTY;
            main_clear = 1'b1;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            state_d       = OCC_ONE;
            main_load     = 1'b1;
            main_sel_skid = skid_valid;
            skid_clear    = 1'b1;
          end
        end
        default: begin
          state_d    = OCC_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_in = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_sel_skid ? skid_data : in_data;

  pipe_skid_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear_i (main_clear),
    .load_i  (main_load),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      pipe_skid_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );

      // Registered ready: decided from the next occupancy, so out_ready
      // never reaches in_ready combinationally.
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != OCC_TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = out_ready | ~main_valid;
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid;
  // The slot already zeroes control when empty; the mask keeps bubbles
  // harmless even if that ever changes.
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;
  assign stall_cnt = stall_cnt_q;

endmodule
